// File: rtl/write_flash_pkg.sv
// Shared encodings for the NAND page-program sequencer: state codes and block-status codes.
// The page-read sequencer also uses the block-status codes.
package write_flash_pkg;

    localparam logic [3:0] S_INIT      = 4'd0;
    localparam logic [3:0] S_IDLE      = 4'd1;
    localparam logic [3:0] S_START     = 4'd2;
    localparam logic [3:0] S_CHK_BAD   = 4'd3;
    localparam logic [3:0] S_ECC_GEN   = 4'd4;
    localparam logic [3:0] S_PROGRAM   = 4'd5;
    localparam logic [3:0] S_WAIT_PROG = 4'd6;
    localparam logic [3:0] S_CHK_STAT  = 4'd7;
    localparam logic [3:0] S_RETRY     = 4'd8;
    localparam logic [3:0] S_MARK_BAD  = 4'd9;
    localparam logic [3:0] S_NEXT_BLK  = 4'd10;
    localparam logic [3:0] S_ERROR     = 4'd11;
    localparam logic [3:0] S_DONE      = 4'd12;
    localparam logic [3:0] S_END       = 4'd13;
    localparam logic [3:0] S_VERIFY    = 4'd14;

    localparam logic [1:0] ROW_PEND = 2'd0;
    localparam logic [1:0] ROW_GOOD = 2'd1;
    localparam logic [1:0] ROW_BAD  = 2'd2;

    // States in which the operation timer runs; it is held clear everywhere else.
    function automatic logic is_timed_state(input logic [3:0] st);
        return (st == S_WAIT_PROG) || (st == S_VERIFY);
    endfunction

endpackage

// File: rtl/flash_op_timer.sv
// Saturating operation timer: held at zero while clear, counts while enabled,
// expire asserts on the last allowed cycle (count == TIMEOUT_CYCLES-1).
module flash_op_timer #(
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count_r;

    // Cycle counter, saturates at LAST so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (clear) begin
            count_r <= {W{1'b0}};
        end else if (enable && (count_r != LAST)) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = enable && (count_r == LAST);

endmodule

// File: rtl/write_flash_state_control.sv
// Page-program sequencer: bad-block check, ECC, program, status check, retry or retire.
// Optional read-back verify after a good program status is enabled by defining WRITE_VERIFY_EN.
module write_flash_state_control #(
    parameter int MAX_RETRY      = 2,
    parameter int MAX_SKIP       = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_write,
    input  logic [1:0] write_addr_row_error,
    input  logic       ecc_gen_done,
    input  logic       prog_done,
    input  logic       prog_fail,
    input  logic       mark_done,
    input  logic       verify_done,
    input  logic       verify_ok,
    output logic       prog_start,
    output logic       mark_bad_start,
    output logic       next_block_req,
    output logic       verify_start,
    output logic       write_done,
    output logic       write_err,
    output logic [3:0] write_state
);

    import write_flash_pkg::*;

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int SW = (MAX_SKIP > 0) ? $clog2(MAX_SKIP + 1) : 1;
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [SW-1:0] SKIP_SAT  = SW'(MAX_SKIP);
    localparam logic [SW-1:0] SKIP_LAST = SW'((MAX_SKIP > 0) ? MAX_SKIP - 1 : 0);

    logic [3:0]    state_r, next_state_s;
    logic          dly_r, fail_r;
    logic [RW-1:0] retry_cnt_r;
    logic [SW-1:0] skip_cnt_r;
    logic          timer_expire_s;
    logic          prog_start_r, mark_bad_start_r, next_block_req_r;
    logic          verify_start_r, write_done_r, write_err_r;
    logic          prog_start_s, mark_bad_start_s, next_block_req_s;
    logic          verify_start_s, write_done_s, write_err_s;

    flash_op_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!is_timed_state(state_r)),
        .enable (is_timed_state(state_r)),
        .expire (timer_expire_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_INIT;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_INIT:      next_state_s = S_IDLE;
            S_IDLE:      if (en_write) next_state_s = S_START; else next_state_s = S_IDLE;
            S_START:     next_state_s = S_CHK_BAD;
            S_CHK_BAD: begin
                // The first cycle only lets the block address settle.
                if (!dly_r || (write_addr_row_error == ROW_PEND)) next_state_s = S_CHK_BAD;
                else if (write_addr_row_error == ROW_GOOD)        next_state_s = S_ECC_GEN;
                else                                              next_state_s = S_NEXT_BLK;
            end
            S_ECC_GEN:   if (ecc_gen_done) next_state_s = S_PROGRAM; else next_state_s = S_ECC_GEN;
            S_PROGRAM:   next_state_s = S_WAIT_PROG;
            S_WAIT_PROG: begin
                if (prog_done)           next_state_s = S_CHK_STAT;
                else if (timer_expire_s) next_state_s = S_RETRY;
                else                     next_state_s = S_WAIT_PROG;
            end
`ifdef WRITE_VERIFY_EN
            S_CHK_STAT:  if (fail_r) next_state_s = S_RETRY; else next_state_s = S_VERIFY;
            S_VERIFY: begin
                if (verify_done && verify_ok)        next_state_s = S_DONE;
                else if (verify_done || timer_expire_s) next_state_s = S_RETRY;
                else                                 next_state_s = S_VERIFY;
            end
`else
            S_CHK_STAT:  if (fail_r) next_state_s = S_RETRY; else next_state_s = S_DONE;
`endif
            S_RETRY:     if (retry_cnt_r < RETRY_MAX) next_state_s = S_PROGRAM; else next_state_s = S_MARK_BAD;
            S_MARK_BAD:  if (mark_done) next_state_s = S_NEXT_BLK; else next_state_s = S_MARK_BAD;
            S_NEXT_BLK:  if (skip_cnt_r < SKIP_LAST) next_state_s = S_START; else next_state_s = S_ERROR;
            S_ERROR:     next_state_s = S_END;
            S_DONE:      next_state_s = S_END;
            S_END:       next_state_s = S_IDLE;
            default:     next_state_s = S_INIT;
        endcase
    end

    // Strobe decode: each strobe is registered so it lines up with the state it belongs to.
    always_comb begin
        prog_start_s     = (next_state_s == S_PROGRAM);
        mark_bad_start_s = (next_state_s == S_MARK_BAD) && (state_r != S_MARK_BAD);
        next_block_req_s = (next_state_s == S_NEXT_BLK);
        write_done_s     = (next_state_s == S_DONE);
        write_err_s      = (next_state_s == S_ERROR);
`ifdef WRITE_VERIFY_EN
        verify_start_s   = (next_state_s == S_VERIFY) && (state_r != S_VERIFY);
`else
        verify_start_s   = 1'b0;
`endif
    end

`ifndef WRITE_VERIFY_EN
    logic verify_unused_s;
    assign verify_unused_s = verify_done ^ verify_ok;
`endif

    // Strobe registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prog_start_r     <= 1'b0;
            mark_bad_start_r <= 1'b0;
            next_block_req_r <= 1'b0;
            verify_start_r   <= 1'b0;
            write_done_r     <= 1'b0;
            write_err_r      <= 1'b0;
        end else begin
            prog_start_r     <= prog_start_s;
            mark_bad_start_r <= mark_bad_start_s;
            next_block_req_r <= next_block_req_s;
            verify_start_r   <= verify_start_s;
            write_done_r     <= write_done_s;
            write_err_r      <= write_err_s;
        end
    end

    // Retry/skip counters, settle delay and captured program status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_cnt_r <= {RW{1'b0}};
            skip_cnt_r  <= {SW{1'b0}};
            dly_r       <= 1'b0;
            fail_r      <= 1'b0;
        end else begin
            dly_r <= (state_r == S_CHK_BAD);
            if (next_state_s == S_START)                               retry_cnt_r <= {RW{1'b0}};
            else if ((state_r == S_RETRY) && (retry_cnt_r < RETRY_MAX)) retry_cnt_r <= retry_cnt_r + RW'(1);
            else                                                       retry_cnt_r <= retry_cnt_r;
            if ((state_r == S_IDLE) && en_write)                       skip_cnt_r <= {SW{1'b0}};
            else if ((state_r == S_NEXT_BLK) && (skip_cnt_r != SKIP_SAT)) skip_cnt_r <= skip_cnt_r + SW'(1);
            else                                                       skip_cnt_r <= skip_cnt_r;
            // prog_fail is only valid alongside the prog_done pulse.
            if ((state_r == S_WAIT_PROG) && prog_done) fail_r <= prog_fail;
            else                                       fail_r <= fail_r;
        end
    end

    assign write_state    = state_r;
    assign prog_start     = prog_start_r;
    assign mark_bad_start = mark_bad_start_r;
    assign next_block_req = next_block_req_r;
    assign verify_start   = verify_start_r;
    assign write_done     = write_done_r;
    assign write_err      = write_err_r;

endmodule

// File: tb/tb_write_flash_state_control.sv
// Self-checking bench for write_flash_state_control: strobe scoreboard plus per-scenario state checks.
module tb_write_flash_state_control;

    import write_flash_pkg::*;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_write = 1'b0;
    logic [1:0] row_error = 2'd0;
    logic ecc_gen_done = 1'b0, prog_done = 1'b0, prog_fail = 1'b0, mark_done = 1'b0;
    logic verify_done = 1'b0, verify_ok = 1'b0;
    logic prog_start, mark_bad_start, next_block_req, verify_start, write_done, write_err;
    logic [3:0] write_state;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];
    logic [5:0] strobes;
    localparam logic [3:0] CODES [6] = '{S_PROGRAM, S_MARK_BAD, S_NEXT_BLK, S_VERIFY, S_DONE, S_ERROR};

    always #5 clk = ~clk;

    write_flash_state_control #(.MAX_RETRY(2), .MAX_SKIP(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .en_write(en_write), .write_addr_row_error(row_error),
        .ecc_gen_done(ecc_gen_done), .prog_done(prog_done), .prog_fail(prog_fail),
        .mark_done(mark_done), .verify_done(verify_done), .verify_ok(verify_ok),
        .prog_start(prog_start), .mark_bad_start(mark_bad_start), .next_block_req(next_block_req),
        .verify_start(verify_start), .write_done(write_done), .write_err(write_err),
        .write_state(write_state)
    );

    assign strobes = {write_err, write_done, verify_start, next_block_req, mark_bad_start, prog_start};

    // Scoreboard: each strobe pulse must match the next queued expectation and the shown state.
    always @(negedge clk) begin
        logic [3:0] exp_v;
        if (!rst) begin
            for (int i = 0; i < 6; i++) begin
                if (strobes[i]) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL strobe_unexpected got code %0d in state %0d required none", CODES[i], write_state);
                    end else begin
                        exp_v = exp_q.pop_front();
                        if (exp_v !== CODES[i] || write_state !== CODES[i]) begin
                            errors++;
                            $display("FAIL strobe_order got code %0d in state %0d required %0d", CODES[i], write_state, exp_v);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_state(input logic [3:0] st, input int budget);
        int n = 0;
        while (write_state !== st && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (write_state !== st) begin
            checks++;
            errors++;
            $display("FAIL wait_state got %0d required %0d", write_state, st);
        end
    endtask

    task automatic start_write();
        en_write = 1'b1;
        @(negedge clk);
        en_write = 1'b0;
    endtask

    task automatic pulse_prog(input logic fail);
        prog_done = 1'b1;
        prog_fail = fail;
        @(negedge clk);
        prog_done = 1'b0;
        prog_fail = 1'b0;
    endtask

    task automatic push_pass();
`ifdef WRITE_VERIFY_EN
        exp_q.push_back(S_VERIFY);
`endif
        exp_q.push_back(S_DONE);
    endtask

    task automatic pass_prog();
        wait_state(S_WAIT_PROG, 40);
        pulse_prog(1'b0);
`ifdef WRITE_VERIFY_EN
        wait_state(S_VERIFY, 5);
        verify_done = 1'b1;
        verify_ok = 1'b1;
        @(negedge clk);
        verify_done = 1'b0;
        verify_ok = 1'b0;
`endif
    endtask

    task automatic finish_op(input string name);
        wait_state(S_IDLE, 40);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_leftover got %0d pending strobes required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (write_state !== S_INIT || strobes !== 6'd0) begin
            errors++;
            $display("FAIL reset_state got state %0d strobes %b required 0 000000", write_state, strobes);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (write_state !== S_IDLE) begin
            errors++;
            $display("FAIL init_to_idle got %0d required %0d", write_state, S_IDLE);
        end
    endtask

    task automatic test_good_block();
        logic [3:0] trace [11];
`ifdef WRITE_VERIFY_EN
        trace = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd14, 4'd12, 4'd13};
`else
        trace = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd12, 4'd13, 4'd1};
`endif
        row_error = ROW_GOOD;
        ecc_gen_done = 1'b1;
        exp_q.push_back(S_PROGRAM);
        push_pass();
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (write_state !== trace[i]) begin
                errors++;
                $display("FAIL good_trace[%0d] got %0d required %0d", i, write_state, trace[i]);
            end
            en_write = (i == 0);
            prog_done = (write_state == S_WAIT_PROG);
            verify_done = (write_state == S_VERIFY);
            verify_ok = (write_state == S_VERIFY);
            @(negedge clk);
        end
        en_write = 1'b0;
        prog_done = 1'b0;
        verify_done = 1'b0;
        verify_ok = 1'b0;
        finish_op("good");
    endtask

    task automatic test_retry();
        repeat (3) exp_q.push_back(S_PROGRAM);
        push_pass();
        start_write();
        repeat (2) begin
            wait_state(S_WAIT_PROG, 40);
            pulse_prog(1'b1);
        end
        pass_prog();
        finish_op("retry");
    endtask

    task automatic test_retire();
        repeat (3) exp_q.push_back(S_PROGRAM);
        exp_q.push_back(S_MARK_BAD);
        exp_q.push_back(S_NEXT_BLK);
        repeat (3) exp_q.push_back(S_PROGRAM);
        push_pass();
        start_write();
        repeat (3) begin
            wait_state(S_WAIT_PROG, 40);
            pulse_prog(1'b1);
        end
        wait_state(S_MARK_BAD, 10);
        repeat (3) @(negedge clk);
        mark_done = 1'b1;
        @(negedge clk);
        mark_done = 1'b0;
        checks++;
        if (write_state !== S_NEXT_BLK) begin
            errors++;
            $display("FAIL retire_next_blk got %0d required %0d", write_state, S_NEXT_BLK);
        end
        @(negedge clk);
        checks++;
        if (write_state !== S_START) begin
            errors++;
            $display("FAIL retire_restart got %0d required %0d", write_state, S_START);
        end
        // A fresh block gets the full retry budget again.
        repeat (2) begin
            wait_state(S_WAIT_PROG, 40);
            pulse_prog(1'b1);
        end
        pass_prog();
        finish_op("retire");
    endtask

    task automatic test_bad_skip();
        row_error = ROW_BAD;
        repeat (4) exp_q.push_back(S_NEXT_BLK);
        exp_q.push_back(S_ERROR);
        start_write();
        wait_state(S_END, 60);
        finish_op("bad_skip");
    endtask

    task automatic test_skip_recover();
        row_error = 2'd3;
        repeat (3) exp_q.push_back(S_NEXT_BLK);
        exp_q.push_back(S_PROGRAM);
        push_pass();
        start_write();
        repeat (3) begin
            wait_state(S_NEXT_BLK, 20);
            @(negedge clk);
        end
        row_error = ROW_PEND;
        wait_state(S_CHK_BAD, 5);
        repeat (6) @(negedge clk);
        checks++;
        if (write_state !== S_CHK_BAD) begin
            errors++;
            $display("FAIL pending_hold got %0d required %0d", write_state, S_CHK_BAD);
        end
        row_error = ROW_GOOD;
        pass_prog();
        finish_op("skip_recover");
    endtask

    task automatic test_timeout();
        int n = 0;
        repeat (2) exp_q.push_back(S_PROGRAM);
        push_pass();
        start_write();
        wait_state(S_WAIT_PROG, 40);
        while (write_state == S_WAIT_PROG && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != TO || write_state !== S_RETRY) begin
            errors++;
            $display("FAIL timeout got %0d cycles then state %0d required %0d then %0d", n, write_state, TO, S_RETRY);
        end
        wait_state(S_WAIT_PROG, 10);
        repeat (TO - 1) @(negedge clk);
        checks++;
        if (write_state !== S_WAIT_PROG) begin
            errors++;
            $display("FAIL timeout_last_cycle got %0d required %0d", write_state, S_WAIT_PROG);
        end
        pulse_prog(1'b0);
        checks++;
        if (write_state !== S_CHK_STAT) begin
            errors++;
            $display("FAIL timeout_tie got %0d required %0d", write_state, S_CHK_STAT);
        end
`ifdef WRITE_VERIFY_EN
        wait_state(S_VERIFY, 5);
        verify_done = 1'b1;
        verify_ok = 1'b1;
        @(negedge clk);
        verify_done = 1'b0;
        verify_ok = 1'b0;
`endif
        finish_op("timeout");
    endtask

    task automatic test_back_to_back();
        repeat (2) begin
            exp_q.push_back(S_PROGRAM);
            push_pass();
        end
        en_write = 1'b1;
        pass_prog();
        wait_state(S_END, 10);
        @(negedge clk);
        checks++;
        if (write_state !== S_IDLE) begin
            errors++;
            $display("FAIL b2b_idle got %0d required %0d", write_state, S_IDLE);
        end
        @(negedge clk);
        checks++;
        if (write_state !== S_START) begin
            errors++;
            $display("FAIL b2b_restart got %0d required %0d", write_state, S_START);
        end
        en_write = 1'b0;
        pass_prog();
        finish_op("b2b");
    endtask

    task automatic test_reset_mid();
        exp_q.push_back(S_PROGRAM);
        start_write();
        wait_state(S_WAIT_PROG, 40);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (write_state !== S_INIT || strobes !== 6'd0) begin
            errors++;
            $display("FAIL reset_mid got state %0d strobes %b required 0 000000", write_state, strobes);
        end
        @(negedge clk);
        rst = 1'b0;
        finish_op("reset_mid");
    endtask

`ifdef WRITE_VERIFY_EN
    task automatic test_verify_fail();
        exp_q.push_back(S_PROGRAM);
        exp_q.push_back(S_VERIFY);
        exp_q.push_back(S_PROGRAM);
        push_pass();
        start_write();
        wait_state(S_WAIT_PROG, 40);
        pulse_prog(1'b0);
        wait_state(S_VERIFY, 5);
        verify_done = 1'b1;
        verify_ok = 1'b0;
        @(negedge clk);
        verify_done = 1'b0;
        checks++;
        if (write_state !== S_RETRY) begin
            errors++;
            $display("FAIL verify_miscompare got %0d required %0d", write_state, S_RETRY);
        end
        pass_prog();
        finish_op("verify_fail");
    endtask
`endif

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_good_block();
        test_retry();
        test_retire();
        test_bad_skip();
        test_skip_recover();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
`ifdef WRITE_VERIFY_EN
        test_verify_fail();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
